// File: rtl/rx_pkg.sv
// Shared types for the USB RX packet sequencer: state encoding, status codes
// and the Moore output decode used by the control FSM.
package rx_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_LOAD_SYNC,
        ST_CHECK_SYNC,
        ST_LOAD_PID,
        ST_CHECK_PID,
        ST_TOKEN,
        ST_DATA,
        ST_HS,
        ST_CRC5,
        ST_CRC16,
        ST_DONE,
        ST_ERROR,
        ST_WAIT_EOP
    } rx_state_t;

    localparam logic [1:0] SYNC_OK   = 2'b01;
    localparam logic [2:0] PID_TOKEN = 3'b001;
    localparam logic [2:0] PID_DATA  = 3'b010;
    localparam logic [2:0] PID_HS    = 3'b011;
    localparam logic [1:0] CRC_PASS  = 2'b01;

    typedef struct packed {
        logic clear;
        logic crc_clear;
        logic load_sync;
        logic check_sync;
        logic load_pid;
        logic check_pid;
        logic load_data;
        logic crc_check_5;
        logic crc_check_16;
        logic load_done;
        logic load_error;
        logic rcving;
    } rx_out_t;

    // Every strobe is a pure function of the state the FSM is entering.
    function automatic rx_out_t decode_outputs(input rx_state_t s);
        rx_out_t o;
        o        = '0;
        o.rcving = (s != ST_IDLE);
        case (s)
            ST_START: begin
                o.clear     = 1'b1;
                o.crc_clear = 1'b1;
            end
            ST_LOAD_SYNC:  o.load_sync    = 1'b1;
            ST_CHECK_SYNC: o.check_sync   = 1'b1;
            ST_LOAD_PID:   o.load_pid     = 1'b1;
            ST_CHECK_PID:  o.check_pid    = 1'b1;
            ST_DATA:       o.load_data    = 1'b1;
            ST_CRC5:       o.crc_check_5  = 1'b1;
            ST_CRC16:      o.crc_check_16 = 1'b1;
            ST_DONE:       o.load_done    = 1'b1;
            ST_ERROR:      o.load_error   = 1'b1;
            default:       ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/rx_timeout_timer.sv
// Idle watchdog for the RX sequencer: counts clocks since the last clear and
// saturates at TIMEOUT_CYCLES. Only built when RX_TIMEOUT_EN is defined.
module rx_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 96
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_clear,
    output logic o_expired
);

    localparam int            W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0]  LIMIT = W'(TIMEOUT_CYCLES);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt != LIMIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/rx_packet_sequencer.sv
// USB RX control FSM: steps the RX buffer through sync/PID/payload/CRC and
// reports one done or error pulse per packet. Optional watchdog: RX_TIMEOUT_EN.
module rx_packet_sequencer
    import rx_pkg::*;
#(
    parameter int MAX_DATA_BYTES = 66,
    parameter int TIMEOUT_CYCLES = 96
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start_detect,
    input  logic       byte_complete,
    input  logic       eop,
    input  logic [1:0] sync_status,
    input  logic [2:0] pid_status,
    input  logic [1:0] crc_status,
    output logic       clear,
    output logic       crc_clear,
    output logic       load_sync,
    output logic       check_sync,
    output logic       load_pid,
    output logic       check_pid,
    output logic       load_data,
    output logic       crc_check_5,
    output logic       crc_check_16,
    output logic       load_done,
    output logic       load_error,
    output logic       rcving,
    output rx_state_t  o_dbg_state
);

    localparam int               CNT_W   = $clog2(MAX_DATA_BYTES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DATA_BYTES);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

    rx_state_t        r_state;
    rx_state_t        w_next;
    rx_out_t          r_out;
    logic [CNT_W-1:0] r_byte_cnt;
    logic [CNT_W-1:0] w_cnt_upd;
    logic             r_eop_seen;
    logic             w_timeout;

`ifdef RX_TIMEOUT_EN
    logic w_timer_clear;

    assign w_timer_clear = (r_state == ST_IDLE) || (r_state == ST_START) ||
                           byte_complete || eop;

    rx_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .i_clear  (w_timer_clear),
        .o_expired(w_timeout)
    );
`else
    // Watchdog absent: expiry is a constant false.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // Byte is counted before eop is judged, so a same-cycle byte+eop sees it.
    assign w_cnt_upd = (byte_complete && (r_byte_cnt != CNT_MAX)) ?
                       r_byte_cnt + 1'b1 : r_byte_cnt;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:       if (start_detect) w_next = ST_START;
            ST_START:      w_next = ST_LOAD_SYNC;
            ST_LOAD_SYNC: begin
                if (eop)                w_next = ST_ERROR;
                else if (byte_complete) w_next = ST_CHECK_SYNC;
            end
            ST_CHECK_SYNC: w_next = (sync_status == SYNC_OK) ? ST_LOAD_PID : ST_ERROR;
            ST_LOAD_PID: begin
                if (eop)                w_next = ST_ERROR;
                else if (byte_complete) w_next = ST_CHECK_PID;
            end
            ST_CHECK_PID: begin
                case (pid_status)
                    PID_TOKEN: w_next = ST_TOKEN;
                    PID_DATA:  w_next = ST_DATA;
                    PID_HS:    w_next = ST_HS;
                    default:   w_next = ST_ERROR;
                endcase
            end
            ST_TOKEN: begin
                if (byte_complete && (r_byte_cnt == CNT_TWO)) w_next = ST_ERROR;
                else if (eop) w_next = (w_cnt_upd == CNT_TWO) ? ST_CRC5 : ST_ERROR;
            end
            ST_DATA: begin
                if (byte_complete && (r_byte_cnt == CNT_MAX)) w_next = ST_ERROR;
                else if (eop) w_next = (w_cnt_upd >= CNT_TWO) ? ST_CRC16 : ST_ERROR;
            end
            ST_HS: begin
                if (byte_complete) w_next = ST_ERROR;
                else if (eop)      w_next = ST_DONE;
            end
            ST_CRC5:     w_next = (crc_status == CRC_PASS) ? ST_DONE : ST_ERROR;
            ST_CRC16:    w_next = (crc_status == CRC_PASS) ? ST_DONE : ST_ERROR;
            ST_DONE:     w_next = ST_IDLE;
            ST_ERROR:    w_next = (r_eop_seen || eop) ? ST_IDLE : ST_WAIT_EOP;
            ST_WAIT_EOP: if (eop) w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase

        // A stall already reported as an error leaves quietly from WAIT_EOP.
        if (w_timeout) begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: ;
                ST_WAIT_EOP: w_next = ST_IDLE;
                default:     w_next = ST_ERROR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= ST_IDLE;
            r_out      <= '0;
            r_byte_cnt <= '0;
            r_eop_seen <= 1'b0;
        end else begin
            r_state <= w_next;
            r_out   <= decode_outputs(w_next);

            if ((r_state == ST_IDLE) || (r_state == ST_START)) begin
                r_byte_cnt <= '0;
            end else if ((r_state == ST_TOKEN) || (r_state == ST_DATA)) begin
                r_byte_cnt <= w_cnt_upd;
            end

            if (r_state == ST_IDLE) begin
                r_eop_seen <= 1'b0;
            end else if (eop) begin
                r_eop_seen <= 1'b1;
            end
        end
    end

    assign clear        = r_out.clear;
    assign crc_clear    = r_out.crc_clear;
    assign load_sync    = r_out.load_sync;
    assign check_sync   = r_out.check_sync;
    assign load_pid     = r_out.load_pid;
    assign check_pid    = r_out.check_pid;
    assign load_data    = r_out.load_data;
    assign crc_check_5  = r_out.crc_check_5;
    assign crc_check_16 = r_out.crc_check_16;
    assign load_done    = r_out.load_done;
    assign load_error   = r_out.load_error;
    assign rcving       = r_out.rcving;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_rx_packet_sequencer.sv
// Bench for rx_packet_sequencer: a default instance and a MAX_DATA_BYTES=4
// instance share stimulus; outcomes are checked against a packet-level model.
module tb_rx_packet_sequencer;
    import rx_pkg::*;

    localparam int MAXB  = 66;
    localparam int SMALL = 4;
    localparam int TMO   = 96;
    localparam int O_CLR = 11, O_LD = 5, O_C5 = 4, O_C16 = 3;
    localparam int O_DONE = 2, O_ERR = 1, O_RCV = 0;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start_detect = 1'b0;
    logic       byte_complete = 1'b0;
    logic       eop = 1'b0;
    logic [1:0] sync_status = 2'b00;
    logic [2:0] pid_status = 3'b000;
    logic [1:0] crc_status = 2'b00;
    wire [11:0] a_o;
    wire [11:0] b_o;
    rx_state_t  a_st;
    rx_state_t  b_st;

    int n_checks = 0;
    int n_pass = 0;

    rx_packet_sequencer dut_a (
        .clk(clk), .n_rst(n_rst), .start_detect(start_detect),
        .byte_complete(byte_complete), .eop(eop), .sync_status(sync_status),
        .pid_status(pid_status), .crc_status(crc_status),
        .clear(a_o[11]), .crc_clear(a_o[10]), .load_sync(a_o[9]),
        .check_sync(a_o[8]), .load_pid(a_o[7]), .check_pid(a_o[6]),
        .load_data(a_o[5]), .crc_check_5(a_o[4]), .crc_check_16(a_o[3]),
        .load_done(a_o[2]), .load_error(a_o[1]), .rcving(a_o[0]),
        .o_dbg_state(a_st)
    );

    rx_packet_sequencer #(.MAX_DATA_BYTES(SMALL)) dut_b (
        .clk(clk), .n_rst(n_rst), .start_detect(start_detect),
        .byte_complete(byte_complete), .eop(eop), .sync_status(sync_status),
        .pid_status(pid_status), .crc_status(crc_status),
        .clear(b_o[11]), .crc_clear(b_o[10]), .load_sync(b_o[9]),
        .check_sync(b_o[8]), .load_pid(b_o[7]), .check_pid(b_o[6]),
        .load_data(b_o[5]), .crc_check_5(b_o[4]), .crc_check_16(b_o[3]),
        .load_done(b_o[2]), .load_error(b_o[1]), .rcving(b_o[0]),
        .o_dbg_state(b_st)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- output monitor (negedge sampling) ----------------
    int a_done_n = 0, a_err_n = 0, b_done_n = 0, b_err_n = 0;
    int a_done_cyc = -1, a_err_cyc = -1, b_err_cyc = -1;
    int crc5_n = 0, crc16_n = 0, crc16_cyc = -1, ld_n = 0, ld_rise = -1;
    int clr_n = 0;
    logic ld_prev = 1'b0;
    bit both_hi = 1'b0;

    always @(negedge clk) begin
        if (a_o[O_DONE]) begin a_done_n++; a_done_cyc = cyc; end
        if (a_o[O_ERR])  begin a_err_n++;  a_err_cyc  = cyc; end
        if (b_o[O_DONE]) b_done_n++;
        if (b_o[O_ERR])  begin b_err_n++;  b_err_cyc  = cyc; end
        if ((a_o[O_DONE] && a_o[O_ERR]) || (b_o[O_DONE] && b_o[O_ERR])) both_hi = 1'b1;
        if (a_o[O_C5]) crc5_n++;
        if (a_o[O_C16]) begin crc16_n++; crc16_cyc = cyc; end
        if (a_o[O_CLR]) clr_n++;
        if (a_o[O_LD]) begin
            if (!ld_prev) ld_rise = cyc;
            ld_n++;
        end
        ld_prev = a_o[O_LD];
    end

    // ---------------- reference model ----------------
    // Packet-level outcome: 1 = done, 0 = error.
    function automatic bit model_ok(input logic [1:0] ss, input logic [2:0] ps,
                                    input logic [1:0] cs, input int nb, input int maxb);
        if (ss != 2'b01) return 1'b0;
        case (ps)
            3'b001:  return (nb == 2) && (cs == 2'b01);
            3'b010:  return (nb >= 2) && (nb <= maxb) && (cs == 2'b01);
            3'b011:  return (nb == 0);
            default: return 1'b0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic b, input logic e);
        byte_complete = b;
        eop = e;
        tick(1);
        byte_complete = 1'b0;
        eop = 1'b0;
    endtask

    task automatic preamble(input logic [1:0] ss, input logic [2:0] ps, input logic [1:0] cs,
                            output int sync_cyc, output int pid_cyc);
        sync_status = ss;
        pid_status  = ps;
        crc_status  = cs;
        start_detect = 1'b1;
        tick(1);
        start_detect = 1'b0;
        tick(1);
        sync_cyc = cyc;
        pulse(1'b1, 1'b0);
        tick(1);
        pid_cyc = cyc;
        pulse(1'b1, 1'b0);
        tick(1);
    endtask

    task automatic send_packet(input logic [1:0] ss, input logic [2:0] ps, input logic [1:0] cs,
                               input int nb, input bit both, input int gap,
                               output int sync_cyc, output int pid_cyc,
                               output int last_cyc, output int eop_cyc);
        last_cyc = -1;
        eop_cyc  = -1;
        preamble(ss, ps, cs, sync_cyc, pid_cyc);
        for (int i = 0; i < nb; i++) begin
            last_cyc = cyc;
            if ((i == nb - 1) && both) begin
                eop_cyc = cyc;
                pulse(1'b1, 1'b1);
            end else begin
                pulse(1'b1, 1'b0);
                tick($urandom_range(0, gap));
            end
        end
        if (eop_cyc < 0) begin
            eop_cyc = cyc;
            pulse(1'b0, 1'b1);
        end
        tick(4);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tick(2);
        n_checks++;
        if (a_o !== 12'h000) $display("FAIL reset_out_a: got %h expected 000", a_o); else n_pass++;
        n_checks++;
        if (b_o !== 12'h000) $display("FAIL reset_out_b: got %h expected 000", b_o); else n_pass++;
        n_checks++;
        if (a_st !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", a_st, ST_IDLE); else n_pass++;
        n_rst = 1'b1;
        tick(2);
        n_checks++;
        if (a_o !== 12'h000) $display("FAIL idle_out: got %h expected 000", a_o); else n_pass++;
    endtask

    task automatic test_token_good(input bit both);
        int s, p, l, e, d0, e0, c0, k0;
        d0 = a_done_n; e0 = a_err_n; c0 = crc5_n; k0 = clr_n;
        send_packet(2'b01, 3'b001, 2'b01, 2, both, 2, s, p, l, e);
        n_checks++;
        if (a_done_n - d0 != 1) $display("FAIL token_done_cnt(both=%0d): got %0d expected 1", both, a_done_n - d0); else n_pass++;
        n_checks++;
        if (a_err_n - e0 != 0) $display("FAIL token_err_cnt(both=%0d): got %0d expected 0", both, a_err_n - e0); else n_pass++;
        n_checks++;
        if (a_done_cyc != e + 2) $display("FAIL token_done_lat: got %0d expected %0d", a_done_cyc - e, 2); else n_pass++;
        n_checks++;
        if (crc5_n - c0 != 1) $display("FAIL token_crc5_cycles: got %0d expected 1", crc5_n - c0); else n_pass++;
        n_checks++;
        if (clr_n - k0 != 1) $display("FAIL token_clear_cycles: got %0d expected 1", clr_n - k0); else n_pass++;
    endtask

    task automatic test_handshake();
        int s, p, l, e, d0, e0;
        d0 = a_done_n; e0 = a_err_n;
        send_packet(2'b01, 3'b011, 2'b00, 0, 1'b0, 0, s, p, l, e);
        n_checks++;
        if (a_done_n - d0 != 1 || a_err_n != e0) $display("FAIL hs_outcome: got done=%0d err=%0d expected 1/0", a_done_n - d0, a_err_n - e0); else n_pass++;
        n_checks++;
        if (a_done_cyc != e + 1) $display("FAIL hs_done_lat: got %0d expected 1", a_done_cyc - e); else n_pass++;
        d0 = a_done_n; e0 = a_err_n;
        send_packet(2'b01, 3'b011, 2'b01, 1, 1'b0, 3, s, p, l, e);
        n_checks++;
        if (a_err_n - e0 != 1 || a_done_n != d0) $display("FAIL hs_extra_byte: got done=%0d err=%0d expected 0/1", a_done_n - d0, a_err_n - e0); else n_pass++;
        n_checks++;
        if (a_err_cyc != l + 1) $display("FAIL hs_extra_err_lat: got %0d expected 1", a_err_cyc - l); else n_pass++;
    endtask

    task automatic test_data_crc_fail();
        int s, p, l, e, d0, e0, n0, c0;
        d0 = a_done_n; e0 = a_err_n; n0 = ld_n; c0 = crc16_n;
        send_packet(2'b01, 3'b010, 2'b00, 4, 1'b0, 2, s, p, l, e);
        n_checks++;
        if (ld_rise != p + 2) $display("FAIL data_ld_rise: got %0d expected %0d", ld_rise - p, 2); else n_pass++;
        n_checks++;
        if (ld_n - n0 != e - p - 1) $display("FAIL data_ld_span: got %0d expected %0d", ld_n - n0, e - p - 1); else n_pass++;
        n_checks++;
        if (crc16_n - c0 != 1 || crc16_cyc != e + 1) $display("FAIL data_crc16: got n=%0d at +%0d expected 1 at +1", crc16_n - c0, crc16_cyc - e); else n_pass++;
        n_checks++;
        if (a_err_n - e0 != 1 || a_done_n != d0) $display("FAIL data_outcome: got done=%0d err=%0d expected 0/1", a_done_n - d0, a_err_n - e0); else n_pass++;
        n_checks++;
        if (a_err_cyc != e + 2) $display("FAIL data_err_lat: got %0d expected 2", a_err_cyc - e); else n_pass++;
        n_checks++;
        if (a_o[O_RCV] !== 1'b0) $display("FAIL data_rcving_after: got %b expected 0", a_o[O_RCV]); else n_pass++;
    endtask

    task automatic test_bad_sync();
        int s, p, e0;
        e0 = a_err_n;
        preamble(2'b10, 3'b001, 2'b01, s, p);
        tick(6);
        n_checks++;
        if (a_err_n - e0 != 1 || a_err_cyc != s + 2) $display("FAIL badsync_err: got n=%0d at +%0d expected 1 at +2", a_err_n - e0, a_err_cyc - s); else n_pass++;
        n_checks++;
        if (a_o[O_RCV] !== 1'b1 || a_st !== ST_WAIT_EOP) $display("FAIL badsync_wait: got rcving=%b state=%0d expected 1/%0d", a_o[O_RCV], a_st, ST_WAIT_EOP); else n_pass++;
        start_detect = 1'b1;
        tick(1);
        start_detect = 1'b0;
        n_checks++;
        if (a_st !== ST_WAIT_EOP) $display("FAIL badsync_start_ignored: got %0d expected %0d", a_st, ST_WAIT_EOP); else n_pass++;
        pulse(1'b0, 1'b1);
        n_checks++;
        if (a_o[O_RCV] !== 1'b0) $display("FAIL badsync_rcving_after_eop: got %b expected 0", a_o[O_RCV]); else n_pass++;
        tick(3);
        n_checks++;
        if (a_err_n - e0 != 1) $display("FAIL badsync_single_pulse: got %0d expected 1", a_err_n - e0); else n_pass++;
    endtask

    task automatic test_overflow();
        int s, p, l, e, ad0, ae0, be0, bd0;
        ad0 = a_done_n; ae0 = a_err_n; be0 = b_err_n; bd0 = b_done_n;
        send_packet(2'b01, 3'b010, 2'b01, 5, 1'b0, 2, s, p, l, e);
        n_checks++;
        if (b_err_n - be0 != 1 || b_done_n != bd0) $display("FAIL ovf_small_outcome: got done=%0d err=%0d expected 0/1", b_done_n - bd0, b_err_n - be0); else n_pass++;
        n_checks++;
        if (b_err_cyc != l + 1) $display("FAIL ovf_small_err_lat: got %0d expected 1", b_err_cyc - l); else n_pass++;
        n_checks++;
        if (a_done_n - ad0 != 1 || a_err_n != ae0) $display("FAIL ovf_big_outcome: got done=%0d err=%0d expected 1/0", a_done_n - ad0, a_err_n - ae0); else n_pass++;
        n_checks++;
        if (b_o[O_RCV] !== 1'b0) $display("FAIL ovf_small_idle: got %b expected 0", b_o[O_RCV]); else n_pass++;
    endtask

    task automatic test_reset_mid_data();
        int s, p, ad0, ae0, bd0, be0;
        preamble(2'b01, 3'b010, 2'b01, s, p);
        pulse(1'b1, 1'b0);
        tick(1);
        pulse(1'b1, 1'b0);
        ad0 = a_done_n; ae0 = a_err_n; bd0 = b_done_n; be0 = b_err_n;
        n_rst = 1'b0;
        #2;
        n_checks++;
        if (a_o !== 12'h000 || a_st !== ST_IDLE) $display("FAIL rstmid_out: got %h state=%0d expected 000/%0d", a_o, a_st, ST_IDLE); else n_pass++;
        tick(3);
        n_rst = 1'b1;
        pulse(1'b0, 1'b1);
        tick(3);
        n_checks++;
        if (a_done_n != ad0 || a_err_n != ae0 || b_done_n != bd0 || b_err_n != be0)
            $display("FAIL rstmid_no_pulse: got done=%0d err=%0d expected 0/0", a_done_n - ad0, a_err_n - ae0);
        else n_pass++;
        n_checks++;
        if (a_o !== 12'h000) $display("FAIL rstmid_idle_after: got %h expected 000", a_o); else n_pass++;
    endtask

    task automatic test_stall();
        int s, p, l, d0, e0;
        d0 = a_done_n; e0 = a_err_n;
        preamble(2'b01, 3'b010, 2'b01, s, p);
        pulse(1'b1, 1'b0);
        tick(1);
        l = cyc;
        pulse(1'b1, 1'b0);
        tick(120);
        pulse(1'b0, 1'b1);
        tick(4);
`ifdef RX_TIMEOUT_EN
        n_checks++;
        if (a_err_n - e0 != 1 || a_done_n != d0) $display("FAIL stall_outcome: got done=%0d err=%0d expected 0/1", a_done_n - d0, a_err_n - e0); else n_pass++;
        n_checks++;
        if (a_err_cyc - l < TMO || a_err_cyc - l > TMO + 3) $display("FAIL stall_err_time: got %0d expected %0d..%0d", a_err_cyc - l, TMO, TMO + 3); else n_pass++;
`else
        n_checks++;
        if (a_done_n - d0 != 1 || a_err_n != e0) $display("FAIL stall_outcome: got done=%0d err=%0d expected 1/0", a_done_n - d0, a_err_n - e0); else n_pass++;
`endif
        n_checks++;
        if (a_o[O_RCV] !== 1'b0) $display("FAIL stall_idle_after: got %b expected 0", a_o[O_RCV]); else n_pass++;
    endtask

    task automatic test_random(input int npkt);
        int s, p, l, e, nb, ad0, ae0, bd0, be0, r;
        logic [1:0] ss, cs;
        logic [2:0] ps;
        bit both, ok_a, ok_b;
        for (int k = 0; k < npkt; k++) begin
            ss = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
            cs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
            r  = $urandom_range(0, 5);
            ps = (r > 4) ? 3'b010 : 3'(r);
            nb = $urandom_range(0, 6);
            both = 1'($urandom_range(0, 1));
            ok_a = model_ok(ss, ps, cs, nb, MAXB);
            ok_b = model_ok(ss, ps, cs, nb, SMALL);
            ad0 = a_done_n; ae0 = a_err_n; bd0 = b_done_n; be0 = b_err_n;
            send_packet(ss, ps, cs, nb, both, 2, s, p, l, e);
            n_checks++;
            if (a_done_n - ad0 != int'(ok_a) || a_err_n - ae0 != int'(!ok_a))
                $display("FAIL rand%0d_a ss=%b pid=%b crc=%b nb=%0d: got done=%0d err=%0d expected %0d/%0d",
                         k, ss, ps, cs, nb, a_done_n - ad0, a_err_n - ae0, ok_a, !ok_a);
            else n_pass++;
            n_checks++;
            if (b_done_n - bd0 != int'(ok_b) || b_err_n - be0 != int'(!ok_b))
                $display("FAIL rand%0d_b ss=%b pid=%b crc=%b nb=%0d: got done=%0d err=%0d expected %0d/%0d",
                         k, ss, ps, cs, nb, b_done_n - bd0, b_err_n - be0, ok_b, !ok_b);
            else n_pass++;
            n_checks++;
            if (a_o[O_RCV] !== 1'b0 || b_o[O_RCV] !== 1'b0)
                $display("FAIL rand%0d_idle: got rcving a=%b b=%b expected 0/0", k, a_o[O_RCV], b_o[O_RCV]);
            else n_pass++;
        end
        n_checks++;
        if (both_hi !== 1'b0) $display("FAIL done_err_overlap: got %b expected 0", both_hi); else n_pass++;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_token_good(1'b0);
        test_token_good(1'b1);
        test_handshake();
        test_data_crc_fail();
        test_bad_sync();
        test_overflow();
        test_reset_mid_data();
        test_stall();
        test_random(40);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rx_packet_sequencer.md
# rx_packet_sequencer

Control FSM for the USB RX path. Sequences the RX data buffer through sync, PID, payload and CRC phases by driving its load/check strobes, and decides packet outcome from the buffer's status returns. Sits between the line decoder (start/EOP/byte_complete) and the RX data buffer and CRC units. Emits exactly one done or error pulse per packet.

## Interface
- `MAX_DATA_BYTES`, default 66: maximum bytes after PID in a data packet, including the 2 CRC bytes.
- `TIMEOUT_CYCLES`, default 96: idle clocks between byte/EOP events before abort; used only with the watchdog.
- `clk` in 1: system clock.
- `n_rst` in 1: reset, asynchronous, active-low. One clock domain.
- `start_detect` in 1: first line transition of a packet.
- `byte_complete` in 1: one-cycle pulse; a byte is on `Packet_Data` this cycle.
- `eop` in 1: one-cycle end-of-packet pulse.
- `sync_status` in 2: 01 sync OK, 10 bad, 00 not checked.
- `pid_status` in 3: 001 token, 010 data, 011 handshake, 100 PID error, 000 none.
- `crc_status` in 2: 01 pass, other fail.
- `clear`, `crc_clear` out 1: buffer and CRC init strobes.
- `load_sync`, `check_sync`, `load_pid`, `check_pid`, `load_data` out 1: buffer strobes.
- `crc_check_5`, `crc_check_16` out 1: CRC check strobes.
- `load_done`, `load_error` out 1: one-cycle outcome pulses.
- `rcving` out 1: high while not IDLE.

## Operation
- Outputs are Moore decodes of the state register. All outputs are 0 in reset and in IDLE.
- IDLE: `start_detect` -> START.
- START: `clear` = 1 and `crc_clear` = 1 for one cycle; `byte_cnt` is cleared. Next state is LOAD_SYNC.
- LOAD_SYNC: `load_sync` = 1. On `byte_complete` -> CHECK_SYNC. `eop` -> ERROR.
- CHECK_SYNC: one cycle, `check_sync` = 1, `sync_status` sampled the same cycle. 01 -> LOAD_PID; anything else -> ERROR.
  - The buffer holds the sync byte for only one cycle after capture, so CHECK_SYNC must immediately follow capture.
- LOAD_PID: `load_pid` = 1. On `byte_complete` -> CHECK_PID. `eop` -> ERROR.
- CHECK_PID: one cycle, `check_pid` = 1.
  - 001 -> TOKEN.
  - 010 -> DATA.
  - 011 -> HS.
  - Anything else -> ERROR.
- TOKEN: each `byte_complete` increments `byte_cnt`.
  - A third byte -> ERROR.
  - `eop` with `byte_cnt` == 2 -> CRC5. `eop` otherwise -> ERROR.
- DATA: `load_data` = 1; each `byte_complete` increments `byte_cnt`.
  - A byte arriving when `byte_cnt` == MAX_DATA_BYTES -> ERROR.
  - `eop` with `byte_cnt` >= 2 -> CRC16. `eop` with `byte_cnt` < 2 -> ERROR.
- HS: `eop` -> DONE. `byte_complete` -> ERROR.
- CRC5: `crc_check_5` = 1 for one cycle. `crc_status` 01 -> DONE, else ERROR.
- CRC16: `crc_check_16` = 1 for one cycle. `crc_status` 01 -> DONE, else ERROR.
- DONE: `load_done` = 1 for one cycle, then -> IDLE.
- ERROR: `load_error` = 1 for one cycle.
  - If `eop_seen` is set, or `eop` is high this cycle -> IDLE. Otherwise -> WAIT_EOP.
  - `eop_seen` is set by any `eop` from START onward and cleared in IDLE.
- WAIT_EOP: all strobes 0, `rcving` = 1. `eop` -> IDLE. `start_detect` is ignored.
- Simultaneous `byte_complete` and `eop` in TOKEN or DATA: count the byte first, then evaluate `eop` against the updated count.
- `byte_cnt` width is $clog2(MAX_DATA_BYTES+1). It saturates and never wraps.

## Timing
- IDLE to START: one cycle after `start_detect` is sampled.
- LOAD_x to CHECK_x: on the same edge where the buffer captures the byte.
- Every check state lasts exactly one cycle.
- Token packet: `load_done` rises 2 cycles after the `eop` edge (via CRC5).
- Handshake packet: `load_done` rises 1 cycle after the `eop` edge.
- `load_done` and `load_error` are never high together. At most one of them pulses per START.
- Reset asserted mid-packet: immediately IDLE, all outputs 0, counters 0. No done/error pulse.

## Configuration
- `RX_TIMEOUT_EN` defined: adds a watchdog counter.
  - The counter is cleared in IDLE, in START, and on any `byte_complete` or `eop`.
  - Reaching TIMEOUT_CYCLES in any state other than IDLE, DONE or ERROR -> ERROR.
  - Reaching TIMEOUT_CYCLES in WAIT_EOP -> IDLE without a second `load_error`.
- `RX_TIMEOUT_EN` undefined: no counter. A stalled packet waits indefinitely.

## Structure
- Shared package `rx_pkg` holds:
  - the state enum;
  - sync/PID/CRC status constants (SYNC_OK, PID_TOKEN, PID_DATA, PID_HS, CRC_PASS).
- Sub-module `rx_timeout_timer` holds the watchdog counter. It is instantiated only under `RX_TIMEOUT_EN`.

## Test plan
- Good OUT token: sync OK, pid_status 001, 2 bytes, eop, crc_status 01 -> one `load_done` 2 cycles after eop; `load_error` never asserted.
- Data packet: 4 bytes, eop, crc_status 00 -> `load_data` high for exactly the DATA span, one `crc_check_16` cycle, one `load_error`, then IDLE.
- Bad sync: sync_status 10 -> `load_error` one cycle after CHECK_SYNC; WAIT_EOP until eop; `rcving` low the cycle after eop.
- Overflow: MAX_DATA_BYTES=4, 5 bytes sent -> `load_error` on the 5th byte; later eop returns to IDLE with no second pulse.
- Handshake with extra byte: pid_status 011, then byte_complete -> `load_error`. Simultaneous byte_complete+eop in TOKEN at `byte_cnt`=1 -> CRC5, not ERROR.
- With `RX_TIMEOUT_EN`: stall 96 cycles in DATA -> `load_error`. Reset mid-DATA -> IDLE, all outputs 0, no pulses.
